// File: rtl/io_pkg.sv
// Shared types and constants for the seven-segment display driver.
package io_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } seg7_state_e;

    localparam logic [7:0]  SEG_BLANK        = 8'hFF;
    localparam logic [7:0]  SEG_DASH         = 8'hBF;
    localparam logic [7:0]  SEG_ZERO         = 8'hC0;
    localparam int unsigned SCAN_DIV_DEFAULT = 50000;
    localparam logic [31:0] DEC_MAX          = 32'd99_999_999;
    localparam logic [4:0]  LAST_STEP        = 5'd26;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off.
module seg7_decode (
    input  logic [3:0] nibble,
    output logic [7:0] seg_n
);

    always_comb begin
        seg_n = 8'hFF;
        unique case (nibble)
            4'h0: seg_n = 8'hC0;
            4'h1: seg_n = 8'hF9;
            4'h2: seg_n = 8'hA4;
            4'h3: seg_n = 8'hB0;
            4'h4: seg_n = 8'h99;
            4'h5: seg_n = 8'h92;
            4'h6: seg_n = 8'h82;
            4'h7: seg_n = 8'hF8;
            4'h8: seg_n = 8'h80;
            4'h9: seg_n = 8'h90;
            4'hA: seg_n = 8'h88;
            4'hB: seg_n = 8'h83;
            4'hC: seg_n = 8'hC6;
            4'hD: seg_n = 8'hA1;
            4'hE: seg_n = 8'h86;
            4'hF: seg_n = 8'h8E;
        endcase
    end

endmodule

// File: rtl/io_seg7_driver.sv
// Eight-digit multiplexed seven-segment driver showing a 32-bit value in hex or
// unsigned decimal (serial double-dabble conversion, leading-zero blanking).
module io_seg7_driver
    import io_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] value,
    input  logic        dec_mode,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        busy
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    seg7_state_e state_q;
    logic        snap_mode_q;
    logic [31:0] snap_value_q;
    logic [31:0] bcd_q;
    logic [26:0] shift_q;
    logic [4:0]  step_q;
    logic        busy_q;

    logic [3:0]  disp_q [8];
    logic [7:0]  blank_q;
    logic        ovf_q;

    logic [PW-1:0] presc_q;
    logic [2:0]    index_q;
    logic [2:0]    index_d;
    logic [7:0]    an_n_q;
    logic [7:0]    seg_n_q;
    logic [7:0]    seg_dec;
    logic [7:0]    seg_sel;

    logic [31:0] bcd_adj;
    logic [7:0]  dec_blank;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        dec_blank = '0;
        for (int i = 7; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
            dec_blank[i] = !seen;
        end
    end

    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            snap_mode_q  <= 1'b0;
            snap_value_q <= '0;
            bcd_q        <= '0;
            shift_q      <= '0;
            step_q       <= '0;
            blank_q      <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < 8; i++) disp_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ({dec_mode, value} != {snap_mode_q, snap_value_q}) begin
                        snap_mode_q  <= dec_mode;
                        snap_value_q <= value;
                        bcd_q        <= '0;
                        shift_q      <= value[26:0];
                        step_q       <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= dec_mode ? StConv : StDone;
                    end
                end
                StConv: begin
                    bcd_q   <= {bcd_adj[30:0], shift_q[26]};
                    shift_q <= {shift_q[25:0], 1'b0};
                    step_q  <= step_q + 5'd1;
                    if (step_q == LAST_STEP) state_q <= StDone;
                end
                StDone: begin
                    for (int i = 0; i < 8; i++) begin
                        disp_q[i] <= snap_mode_q ? bcd_q[4*i +: 4] : snap_value_q[4*i +: 4];
                    end
                    blank_q <= snap_mode_q ? dec_blank : 8'h00;
                    ovf_q   <= snap_mode_q && (snap_value_q > DEC_MAX);
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign index_d = (presc_q == PRESC_LAST) ? index_q + 3'd1 : index_q;

    // Decode against the next index so the anode and segment registers move together.
    seg7_decode u_decode (
        .nibble (disp_q[index_d]),
        .seg_n  (seg_dec)
    );

    always_comb begin
        seg_sel = seg_dec;
        if (ovf_q) begin
            seg_sel = SEG_DASH;
        end else if (blank_q[index_d]) begin
            seg_sel = SEG_BLANK;
        end
    end

    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            presc_q <= '0;
            index_q <= '0;
            an_n_q  <= 8'hFE;
            seg_n_q <= SEG_ZERO;
        end else begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            index_q <= index_d;
            an_n_q  <= ~(8'd1 << index_d);
            seg_n_q <= seg_sel;
        end
    end

    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;
    assign busy  = busy_q;

endmodule
